// File: rtl/perceptron_trainer.sv
// perceptron_trainer
//   Control and learning stage of a single-layer perceptron. Holds the weight
//   registers, presents the registered sample (x_out) and weights (w) to an
//   external weighted_sum pipeline, waits SUM_LAT cycles for its result,
//   thresholds it into y and, when training on a mismatch, applies the
//   perceptron rule one weight per cycle.
//
//   Build option: define PERCEPTRON_SAT_EN to saturate weight updates on
//   signed overflow; otherwise updates wrap modulo 2^32.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   in_valid   sample present on x/target/train
//   in_ready   high only while idle; accept = in_valid & in_ready
//   x          binary input vector
//   target     desired output for the sample
//   train      1 = update weights on mismatch, 0 = inference only
//   clr_cnt    clears err_cnt (wins over a coincident increment)
//   x_out      registered sample driven to weighted_sum
//   w          weights, w_i at [32*i+31:32*i], signed two's complement
//   sum        signed result returned by weighted_sum
//   out_valid  one-cycle pulse marking a new y
//   y          thresholded output, held until the next decision
//   err_cnt    saturating mismatch count

module perceptron_trainer #(
   parameter int unsigned        N       = 8,
   parameter int unsigned        SUM_LAT = 8,
   parameter logic [31:0]        LR      = 32'd1,
   parameter logic signed [31:0] THRESH  = 32'sd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N-1:0]      x,
   input  logic              target,
   input  logic              train,
   input  logic              clr_cnt,
   output logic [N-1:0]      x_out,
   output logic [32*N-1:0]   w,
   input  logic [31:0]       sum,
   output logic              out_valid,
   output logic              y,
   output logic [15:0]       err_cnt
);

   localparam int unsigned CNT_W = (SUM_LAT > 1) ? $clog2(SUM_LAT) : 1;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StDecide, StUpdate} state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [IDX_W-1:0]   idx_q;
   logic               target_q;
   logic               train_q;
   logic [31:0]        w_q [N];
   logic               y_new;
   logic               mismatch;
   logic [31:0]        upd_val;

   // Step one weight by +/-LR; on signed overflow either saturate or wrap.
   function automatic logic [31:0] step_weight(input logic [31:0] a, input logic up);
      logic [31:0] r;
      r = up ? (a + LR) : (a - LR);
`ifdef PERCEPTRON_SAT_EN
      if (up ? ((a[31] == LR[31]) && (r[31] != a[31]))
             : ((a[31] != LR[31]) && (r[31] != a[31]))) begin
         r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
`endif
      return r;
   endfunction

   always_comb begin
      y_new    = ($signed(sum) > THRESH);
      mismatch = (y_new != target_q);
      upd_val  = step_weight(w_q[idx_q], target_q);
   end

   for (genvar i = 0; i < N; i++) begin : g_w
      assign w[32*i +: 32] = w_q[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         idx_q     <= '0;
         target_q  <= 1'b0;
         train_q   <= 1'b0;
         x_out     <= '0;
         y         <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         err_cnt   <= '0;
         for (int i = 0; i < N; i++) begin
            w_q[i] <= '0;
         end
      end else begin
         out_valid <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  x_out    <= x;
                  target_q <= target;
                  train_q  <= train;
                  cnt_q    <= '0;
                  in_ready <= 1'b0;
                  state_q  <= StWait;
               end
            end
            StWait: begin
               // x_out and w stay frozen here so the pipeline sees one stable operand set.
               if (cnt_q == CNT_W'(SUM_LAT - 1)) begin
                  state_q <= StDecide;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StDecide: begin
               y         <= y_new;
               out_valid <= 1'b1;
               if (train_q && mismatch) begin
                  idx_q   <= '0;
                  state_q <= StUpdate;
               end else begin
                  in_ready <= 1'b1;
                  state_q  <= StIdle;
               end
            end
            StUpdate: begin
               if (x_out[idx_q]) begin
                  w_q[idx_q] <= upd_val;
               end
               if (idx_q == IDX_W'(N - 1)) begin
                  in_ready <= 1'b1;
                  state_q  <= StIdle;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase

         if (clr_cnt) begin
            err_cnt <= '0;
         end else if ((state_q == StDecide) && mismatch && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer. Two instances share the stimulus:
//   dut    N=8, SUM_LAT=8, LR=1, THRESH=0 (main checks)
//   dut_lr LR=32'h40000000 with THRESH at the positive limit so every trained
//          sample mismatches, driving w0 repeatedly toward overflow.
// Each instance gets its own weighted_sum model delayed by SUM_LAT cycles.

module tb_perceptron_trainer;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [7:0]   x;
   logic         target;
   logic         train;
   logic         clr_cnt;

   logic         in_ready,  in_ready2;
   logic [7:0]   x_out,     x_out2;
   logic [255:0] w,         w2;
   logic [31:0]  sum,       sum2;
   logic         out_valid, out_valid2;
   logic         y,         y2;
   logic [15:0]  err_cnt,   err_cnt2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   perceptron_trainer #(.N(8), .SUM_LAT(8), .LR(32'd1), .THRESH(32'sd0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
      .target(target), .train(train), .clr_cnt(clr_cnt), .x_out(x_out), .w(w),
      .sum(sum), .out_valid(out_valid), .y(y), .err_cnt(err_cnt)
   );

   perceptron_trainer #(.N(8), .SUM_LAT(8), .LR(32'h4000_0000), .THRESH(32'sh7FFF_FFFF)) dut_lr (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .x(x),
      .target(target), .train(train), .clr_cnt(clr_cnt), .x_out(x_out2), .w(w2),
      .sum(sum2), .out_valid(out_valid2), .y(y2), .err_cnt(err_cnt2)
   );

   // weighted_sum model: combinational sum followed by an 8-deep delay line.
   function automatic logic [31:0] wsum(input logic [7:0] xv, input logic [255:0] wv);
      logic [31:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) begin
         if (xv[i]) s = s + wv[32*i +: 32];
      end
      return s;
   endfunction

   logic [31:0] pipe1 [8];
   logic [31:0] pipe2 [8];

   always @(posedge clk) begin
      pipe1[0] <= wsum(x_out, w);
      pipe2[0] <= wsum(x_out2, w2);
      for (int k = 1; k < 8; k++) begin
         pipe1[k] <= pipe1[k-1];
         pipe2[k] <= pipe2[k-1];
      end
   end

   assign sum  = pipe1[7];
   assign sum2 = pipe2[7];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one sample, then run until both instances are idle again.
   // Cycle numbers count from the accept edge (cycle 0).
   task automatic run_txn(input logic [7:0] xv, input logic tv, input logic trv,
                          output int ov_cyc, output int ov_n, output int rdy_cyc);
      x = xv; target = tv; train = trv; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      ov_cyc = -1; ov_n = 0; rdy_cyc = -1;
      for (int cyc = 1; cyc < 60; cyc++) begin
         if (out_valid) begin
            ov_n++;
            if (ov_cyc < 0) ov_cyc = cyc;
         end
         if (in_ready && rdy_cyc < 0) rdy_cyc = cyc;
         if (in_ready && in_ready2) break;
         step();
      end
   endtask

   int ov_cyc, ov_n, rdy_cyc, accepts;
   logic [31:0] exp_sat1, exp_sat2;

   initial begin
`ifdef PERCEPTRON_SAT_EN
      exp_sat1 = 32'h7FFF_FFFF;
      exp_sat2 = 32'h7FFF_FFFF;
`else
      exp_sat1 = 32'h8000_0000;
      exp_sat2 = 32'hC000_0000;
`endif
      rst = 1'b1; in_valid = 1'b0; x = '0; target = 1'b0; train = 1'b0; clr_cnt = 1'b0;

      // 1: reset
      step(); step();
      check("rst_w", w[31:0] | w[63:32] | w[95:64] | w[127:96] | w[159:128] | w[191:160]
                     | w[223:192] | w[255:224], 32'd0);
      check("rst_x_out", 32'(x_out), 32'd0);
      check("rst_y", 32'(y), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      step();

      // 2: train on x=05, target=1 -> y=0, mismatch, w0=w2=1
      run_txn(8'h05, 1'b1, 1'b1, ov_cyc, ov_n, rdy_cyc);
      check("t2_ov_cycle", ov_cyc, 32'd10);
      check("t2_ov_pulses", ov_n, 32'd1);
      check("t2_ready_cycle", rdy_cyc, 32'd18);
      check("t2_y", 32'(y), 32'd0);
      check("t2_err_cnt", 32'(err_cnt), 32'd1);
      check("t2_w0", w[31:0], 32'd1);
      check("t2_w1", w[63:32], 32'd0);
      check("t2_w2", w[95:64], 32'd1);
      check("t2_w7", w[255:224], 32'd0);

      // 3: inference on x=05, target=0 -> sum=2, y=1, mismatch counted, no update
      run_txn(8'h05, 1'b0, 1'b0, ov_cyc, ov_n, rdy_cyc);
      check("t3_ov_cycle", ov_cyc, 32'd10);
      check("t3_ready_cycle", rdy_cyc, 32'd10);
      check("t3_y", 32'(y), 32'd1);
      check("t3_err_cnt", 32'(err_cnt), 32'd2);
      check("t3_w0", w[31:0], 32'd1);
      check("t3_w2", w[95:64], 32'd1);

      // 4a: in_valid held 30 cycles -> accepts at cycles 0, 10, 20 only
      x = 8'h05; target = 1'b1; train = 1'b0; in_valid = 1'b1;
      accepts = 0;
      for (int i = 0; i < 30; i++) begin
         if (in_valid && in_ready) accepts++;
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 40 && !(in_ready && in_ready2); i++) step();
      check("t4_accepts", accepts, 32'd3);
      check("t4_idle", 32'(in_ready), 32'd1);
      check("t4_y", 32'(y), 32'd1);
      check("t4_err_cnt", 32'(err_cnt), 32'd2);

      // 4b: clr_cnt in the DECIDE cycle of a mismatching sample -> clear wins
      x = 8'h01; target = 1'b0; train = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) step();
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      check("t4_clr_out_valid", 32'(out_valid), 32'd1);
      check("t4_clr_y", 32'(y), 32'd1);
      check("t4_clr_err_cnt", 32'(err_cnt), 32'd0);
      for (int i = 0; i < 40 && !(in_ready && in_ready2); i++) step();

      // 6: reset during UPDATE (cycle 12) discards everything
      x = 8'h02; target = 1'b1; train = 1'b1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 11; i++) step();
      check("t6_w1_pre", w[63:32], 32'd2 - 32'd1);
      check("t6_err_pre", 32'(err_cnt), 32'd1);
      check("t6_busy_pre", 32'(in_ready), 32'd0);
      rst = 1'b1;
      step();
      for (int i = 0; i < 8; i++) check($sformatf("t6_w%0d", i), w[32*i +: 32], 32'd0);
      check("t6_in_ready", 32'(in_ready), 32'd1);
      check("t6_out_valid", 32'(out_valid), 32'd0);
      check("t6_err_cnt", 32'(err_cnt), 32'd0);
      check("t6_x_out", 32'(x_out), 32'd0);
      rst = 1'b0;
      step();

      // 5: large LR driven into overflow on w0 of dut_lr
      run_txn(8'h01, 1'b1, 1'b1, ov_cyc, ov_n, rdy_cyc);
      check("t5_w0_pass1", w2[31:0], 32'h4000_0000);
      check("t5_w1_pass1", w2[63:32], 32'd0);
      run_txn(8'h01, 1'b1, 1'b1, ov_cyc, ov_n, rdy_cyc);
      check("t5_w0_pass2", w2[31:0], exp_sat1);
      run_txn(8'h01, 1'b1, 1'b1, ov_cyc, ov_n, rdy_cyc);
      check("t5_w0_pass3", w2[31:0], exp_sat2);
      check("t5_err_cnt", 32'(err_cnt2), 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
